// File: rtl/occupancy_scan_pkg.sv
// occupancy_scan_pkg
// Shared definitions for the occupancy scanner: FSM state encoding,
// comparison-mode encoding and width helper functions.
package occupancy_scan_pkg;

  // Scanner control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Threshold comparison modes
  typedef enum logic {
    CMP_GT = 1'b0,
    CMP_LT = 1'b1
  } cmp_mode_e;

  // Ceiling log2 for positive integers (clog2_int(1) = 0)
  function automatic int clog2_int(input int value);
    int width;
    width = 0;
    while ((32'sd1 << width) < value) begin
      width = width + 32'sd1;
    end
    return width;
  endfunction

  // Width needed to hold a count from 0 to num_ch inclusive
  function automatic int cnt_width(input int num_ch);
    return clog2_int(num_ch + 32'sd1);
  endfunction

  // Width of a channel index; never narrower than one bit
  function automatic int idx_width(input int num_ch);
    return (num_ch > 32'sd1) ? clog2_int(num_ch) : 32'sd1;
  endfunction

endpackage

// File: rtl/occupancy_scan_rd_tag_pipe.sv
// rd_tag_pipe
// RD_LAT-deep shift register that travels alongside the memory read
// latency, so each returning data word arrives together with the channel
// index that requested it.
// Ports:
//   iclk      clock
//   irst      synchronous active-high clear (drops all in-flight tags)
//   in_valid  a read is being issued this cycle
//   in_idx    channel index of the issued read
//   out_valid tag emerging: mem_data belongs to out_idx this cycle
//   out_idx   channel index of the emerging tag
module rd_tag_pipe #(
  parameter int RD_LAT = 1,
  parameter int IDX_W  = 2
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [RD_LAT-1:0] vld;
  logic [IDX_W-1:0]  tag [RD_LAT];

  // Shift the {valid, index} tags one stage per clock
  always_ff @(posedge iclk) begin
    if (irst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      tag[0] <= in_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_idx   = tag[RD_LAT-1];

endmodule

// File: rtl/occupancy_scan.sv
// occupancy_scan
// N-channel threshold scanner. A start pulse issues NUM_CH sequential reads
// at base_addr + i*stride over one shared synchronous memory port, compares
// every returned word against a latched threshold (greater-than or
// less-than, equality never hits) and reports hit mask, hit count and an
// all-hit flag together with a one-cycle done pulse.
// Ports:
//   iclk, irst          clock, synchronous active-high reset
//   start               request pulse, accepted only while idle
//   base_addr, stride   address of channel 0, per-channel increment
//   thresh, cmp_mode    threshold and comparison mode (0: >, 1: <)
//   mem_rd, mem_addr    read strobe and address
//   mem_data            read data, valid RD_LAT cycles after mem_rd
//   busy, done          scan in progress, one-cycle completion pulse
//   hit_mask, hit_count, all_hit   results, held between done pulses
module occupancy_scan
  import occupancy_scan_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 14,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = cnt_width(NUM_CH)
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [DATA_W-1:0] thresh,
  input  logic              cmp_mode,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] hit_mask,
  output logic [CNT_W-1:0]  hit_count,
  output logic              all_hit
);

  localparam int IDX_W = idx_width(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_e            state;
  state_e            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] stride_l;
  logic [DATA_W-1:0] thresh_l;
  cmp_mode_e         mode_l;
  logic [NUM_CH-1:0] work_mask;
  logic [NUM_CH-1:0] mask_nxt;
  logic [CNT_W-1:0]  pop;
  logic              tag_valid;
  logic [IDX_W-1:0]  tag_idx;
  logic              hit;
  logic              last_issue;

  rd_tag_pipe #(
    .RD_LAT (RD_LAT),
    .IDX_W  (IDX_W)
  ) u_rd_tag_pipe (
    .iclk      (iclk),
    .irst      (irst),
    .in_valid  (mem_rd),
    .in_idx    (idx),
    .out_valid (tag_valid),
    .out_idx   (tag_idx)
  );

  assign last_issue = (idx == LAST_IDX);

  // State register
  always_ff @(posedge iclk) begin
    if (irst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. DRAIN ends on the cycle the final channel's tag
  // emerges: that is the last entry in the pipe, so its data is folded
  // into the result while moving to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SCAN;
        end else begin
          state_nxt = IDLE;
        end
      end
      SCAN: begin
        if (last_issue) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = SCAN;
        end
      end
      DRAIN: begin
        if (tag_valid && (tag_idx == LAST_IDX)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Compare the returning word against the latched threshold
  always_comb begin
    hit = 1'b0;
    case (mode_l)
      CMP_GT:  hit = (mem_data > thresh_l);
      CMP_LT:  hit = (mem_data < thresh_l);
      default: hit = 1'b0;
    endcase
  end

  // Working mask including this cycle's returning channel, and its popcount
  always_comb begin
    mask_nxt = work_mask;
    pop      = '0;
    if (tag_valid && hit) begin
      mask_nxt[tag_idx] = 1'b1;
    end else begin
      mask_nxt = work_mask;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + CNT_W'(mask_nxt[i]);
    end
  end

  // Datapath, request latches and registered outputs
  always_ff @(posedge iclk) begin
    if (irst) begin
      idx       <= '0;
      mem_addr  <= '0;
      stride_l  <= '0;
      thresh_l  <= '0;
      mode_l    <= CMP_GT;
      work_mask <= '0;
      mem_rd    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_mask  <= '0;
      hit_count <= '0;
      all_hit   <= 1'b0;
    end else begin
      mem_rd <= (state_nxt == SCAN);
      busy   <= (state_nxt == SCAN) || (state_nxt == DRAIN);
      done   <= (state_nxt == DONE);
      if ((state == IDLE) && start) begin
        idx       <= '0;
        mem_addr  <= base_addr;
        stride_l  <= stride;
        thresh_l  <= thresh;
        mode_l    <= cmp_mode_e'(cmp_mode);
        work_mask <= '0;
      end else begin
        // Running address adder; wraps modulo 2^ADDR_W by truncation
        if ((state == SCAN) && !last_issue) begin
          idx      <= idx + IDX_W'(1);
          mem_addr <= mem_addr + stride_l;
        end
        work_mask <= mask_nxt;
      end
      // Results land together with done and hold until the next scan ends
      if (state_nxt == DONE) begin
        hit_mask  <= mask_nxt;
        hit_count <= pop;
        all_hit   <= &mask_nxt;
      end
    end
  end

endmodule
